// File: rtl/icache_refill_unit.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_unit
// Description : AXI4 read master that refills one instruction-cache block.
//               Issues a single INCR burst for the block-aligned miss
//               address, packs the returned beats (beat 0 = LSW) into one
//               block and hands it to the icache with a one-cycle strobe.
//               Protocol/response errors yield a one-cycle error pulse
//               instead of the write.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_unit #(
    parameter int ADDR_WIDTH     = 64,
    parameter int BLOCK_WIDTH    = 512,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                      i_clk,
    input  logic                      i_arst,
    input  logic                      i_start,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic [ADDR_WIDTH-1:0]     o_araddr,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rlast,
    input  logic                      i_rvalid,
    output logic                      o_rready,
    output logic [BLOCK_WIDTH-1:0]    o_instr_block,
    output logic                      o_instr_we,
    output logic                      o_busy,
    output logic                      o_error
);

    localparam int c_BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
    localparam int c_CNT_W = $clog2(c_BEATS);
    localparam int c_OFFS  = $clog2(BLOCK_WIDTH / 8);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_BEATS - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ADDR  = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_WRITE = 2'd3;

    logic [1:0]               r_state;
    logic [c_CNT_W-1:0]       r_cnt;
    logic                     r_err;
    logic [ADDR_WIDTH-1:0]    r_araddr;
    logic                     r_arvalid;
    logic                     r_rready;
    logic                     r_instr_we;
    logic                     r_error;
    logic                     r_busy;
    logic [BLOCK_WIDTH-1:0]   r_block;

    logic                     w_ar_hs;
    logic                     w_rd_hs;
    logic                     w_cnt_last;
    logic                     w_final;
    logic                     w_err_now;
    logic [ADDR_WIDTH-1:0]    w_aligned_addr;
    logic                     w_unused_addr_lsbs;

    // Burst shape is fixed by the block geometry
    assign o_arlen   = 8'(c_BEATS - 1);
    assign o_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign o_arburst = 2'b01;

    // Byte offset within the block is discarded; fetch already aligns it
    assign w_aligned_addr     = {i_addr[ADDR_WIDTH-1:c_OFFS], {c_OFFS{1'b0}}};
    assign w_unused_addr_lsbs = ^i_addr[c_OFFS-1:0];

    assign w_ar_hs    = r_arvalid & i_arready;
    assign w_rd_hs    = r_rready & i_rvalid;
    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    // Burst ends on the expected last beat or on an early RLAST, whichever first
    assign w_final    = w_rd_hs & (w_cnt_last | i_rlast);
    // Error state including the beat currently being accepted
    assign w_err_now  = r_err
                      | (i_rresp != 2'b00)
                      | (i_rlast & ~w_cnt_last)
                      | (~i_rlast & w_cnt_last);

    // Refill control FSM with registered handshake and status outputs
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_araddr   <= '0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_instr_we <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_instr_we <= 1'b0;
            r_error    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (i_start) begin
                        r_state   <= c_ST_ADDR;
                        r_araddr  <= w_aligned_addr;
                        r_cnt     <= '0;
                        r_err     <= 1'b0;
                        r_arvalid <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                c_ST_ADDR: begin
                    if (w_ar_hs) begin
                        r_state   <= c_ST_DATA;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (w_rd_hs) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        r_err <= w_err_now;
                        if (w_final) begin
                            r_state    <= c_ST_WRITE;
                            r_rready   <= 1'b0;
                            r_instr_we <= ~w_err_now;
                            r_error    <= w_err_now;
                        end
                    end
                end
                c_ST_WRITE: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Beat assembly: each accepted beat lands in its slot, beat 0 at the LSW
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_block <= '0;
        end else if (w_rd_hs) begin
            r_block[r_cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
        end
    end

    assign o_araddr      = r_araddr;
    assign o_arvalid     = r_arvalid;
    assign o_rready      = r_rready;
    assign o_instr_block = r_block;
    assign o_instr_we    = r_instr_we;
    assign o_busy        = r_busy;
    assign o_error       = r_error;

endmodule
`default_nettype wire

// File: doc/icache_refill_unit.md
Name: icache_refill_unit

Overview:
- AXI4 read master that services instruction-cache misses for the fetch stage.
- On a miss it takes the block-aligned fetch address and issues one INCR burst.
- It assembles the returned beats into a single cache block.
- It presents the block with a one-cycle write enable to the instruction cache. This is the memory-side counterpart of the fetch stage's read-address / block-write interface.

Parameters:
ADDR_WIDTH, 64, fetch/AXI address width
BLOCK_WIDTH, 512, cache block width in bits
AXI_DATA_WIDTH, 32, AXI read data bus width; BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH (power of 2, 2..256)

Ports:
i_clk  input  1  clock
i_arst  input  1  asynchronous reset, active-low
i_start  input  1  refill request (icache miss); level, sampled only in IDLE
i_addr  input  ADDR_WIDTH  miss address (block-aligned by fetch; low log2(BLOCK_WIDTH/8) bits forced to 0 internally)
o_araddr  output  ADDR_WIDTH  AXI read address
o_arlen  output  8  BEATS-1
o_arsize  output  3  log2(AXI_DATA_WIDTH/8)
o_arburst  output  2  constant 2'b01 (INCR)
o_arvalid  output  1  AXI AR valid
i_arready  input  1  AXI AR ready
i_rdata  input  AXI_DATA_WIDTH  AXI read data
i_rresp  input  2  AXI read response
i_rlast  input  1  AXI last beat
i_rvalid  input  1  AXI R valid
o_rready  output  1  AXI R ready
o_instr_block  output  BLOCK_WIDTH  assembled block to icache
o_instr_we  output  1  one-cycle block write strobe to icache
o_busy  output  1  refill in progress (state != IDLE)
o_error  output  1  one-cycle pulse: burst failed, block not written

Behaviour:
- Reset (i_arst low, asynchronous): state IDLE; beat counter 0; o_arvalid, o_rready, o_instr_we, o_busy, o_error = 0; o_araddr = 0; o_instr_block = 0; error flag cleared.
- Reset mid-burst aborts immediately, with no write and no error pulse. The AXI slave is reset on the same signal.
- FSM states: IDLE, ADDR, DATA, WRITE.
- IDLE -> ADDR when i_start = 1. On that edge, latch o_araddr = i_addr with the low 6 bits zeroed (for default params) and clear the beat counter and error flag.
- ADDR: o_arvalid = 1. o_araddr, o_arlen, o_arsize and o_arburst are held stable. On i_arvalid & i_arready -> DATA. There is no combinational path from i_arready to o_arvalid.
- DATA: o_rready = 1. On each i_rvalid & o_rready handshake, beat k (counter value) is written to o_instr_block[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH], i.e. beat 0 is the least-significant word. The counter then increments.
- DATA error conditions:
  - i_rresp != 2'b00 on any beat sets the sticky error flag.
  - i_rlast = 1 on beat k < BEATS-1 sets the error flag and ends the burst (-> WRITE).
  - i_rlast = 0 on beat BEATS-1 sets the error flag. The burst still ends on that beat. Any further beats are outside the protocol.
  - The final handshake (counter = BEATS-1 or i_rlast) -> WRITE.
- WRITE, exactly one cycle: if the error flag is clear, o_instr_we = 1; otherwise o_error = 1 and o_instr_we = 0. Always -> IDLE.
- o_instr_block holds its value from WRITE until the first beat of the next refill.
- i_start in the IDLE cycle after WRITE is honoured. The icache has updated on the WRITE edge, so the fetch stage deasserts the miss by then.
- Latency with zero-wait slave: i_start at cycle 0; o_arvalid in cycles 1..; first beat no earlier than cycle 2; o_instr_we one cycle after the final beat handshake. Minimum total is BEATS+3 cycles.
- i_start and i_addr are ignored outside IDLE. Only one outstanding burst is allowed.
- All outputs are registered except the constant o_arlen, o_arsize and o_arburst.

Test Plan:
1. Reset low mid-DATA (after beat 5) -> all outputs 0 and state IDLE within the same cycle. No o_instr_we or o_error. A new i_start after release runs a clean burst.
2. i_start with i_addr=0x0000_0000_8000_1234, i_arready=1, zero-wait slave returning rdata=beat index, rlast on beat 15 -> the following AR and write-strobe behaviour is produced:
   - araddr=0x8000_1200, arlen=15, arsize=2, arburst=1.
   - o_instr_we pulses once with o_instr_block[31:0]=0 and [511:480]=15.
   - o_busy drops the next cycle.
3. i_arready held low 7 cycles, i_rvalid toggled every other cycle -> o_arvalid and o_araddr are stable until handshake. The block is assembled correctly, and o_instr_we arrives one cycle after beat 15.
4. i_rresp=2'b10 on beat 3 only -> all 16 beats are consumed. o_error pulses once, o_instr_we stays 0, and the next refill with OKAY writes normally.
5. i_rlast asserted early on beat 9 -> o_error pulses and no write occurs. Separately, i_rlast missing on beat 15 -> o_error pulses after beat 15.
6. i_start held high across WRITE with new i_addr -> a second AR is issued from IDLE for the new aligned address, and the first block's write occurs exactly once.
